// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Purpose:
//   Shares one single-port, synchronous-read data SRAM between NUM_CORES
//   single-cycle MIPS cores. Requests are arbitrated round-robin. Each access
//   takes an IDLE cycle, which drives the SRAM address and commits stores,
//   followed by a RESP cycle, which returns read data and pulses done. Every
//   requesting core that is not being completed is stalled.
//
// Ports:
//   clk         in   single clock
//   reset       in   asynchronous, active-low reset
//   req         in   [NUM_CORES]        per-core access request
//   we          in   [NUM_CORES]        per-core write enable (1 = store)
//   addr        in   [NUM_CORES*ADDR_W] per-core byte address, core i at
//                                       [i*ADDR_W +: ADDR_W]
//   wdata       in   [NUM_CORES*32]     per-core store data
//   stall       out  [NUM_CORES]        per-core stall (req & ~done)
//   rdata       out  [32]               load data broadcast to all cores
//   done        out  [NUM_CORES]        one-hot access-complete pulse
//   sram_addr   out  [ADDR_W]           SRAM address
//   sram_we     out                     SRAM write enable
//   sram_wdata  out  [32]               SRAM write data
//   sram_rdata  in   [32]               SRAM read data (valid one cycle
//                                       after the address)
//   grant_cnt   out  [NUM_CORES*16]     saturating per-core completion
//                                       counters (only with
//                                       DMEM_ARBITER_STATS_EN defined)
//
// Optional build macro:
//   DMEM_ARBITER_STATS_EN - adds the grant_cnt port and its counters.
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [NUM_CORES-1:0]        we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr,
  input  logic [NUM_CORES*32-1:0]     wdata,
  output logic [NUM_CORES-1:0]        stall,
  output logic [31:0]                 rdata,
  output logic [NUM_CORES-1:0]        done,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic                        sram_we,
  output logic [31:0]                 sram_wdata,
  input  logic [31:0]                 sram_rdata
`ifdef DMEM_ARBITER_STATS_EN
  ,
  output logic [NUM_CORES*16-1:0]     grant_cnt
`endif
);

  // The FSM has only two states: arbitrate/issue and respond.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] ptr;

  // Per-core address and data buses unpacked into arrays so that the
  // multiplexers can be indexed directly by the grant index.
  logic [ADDR_W-1:0] addr_arr  [NUM_CORES];
  logic [31:0]       wdata_arr [NUM_CORES];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
    assign addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = wdata[g*32 +: 32];
  end

  // Round-robin search. The request vector is rotated right by ptr, so bit j
  // of req_rot belongs to core (ptr + j) mod NUM_CORES. The lowest set bit is
  // the offset of the winner from ptr.
  logic                   any_req;
  logic [2*NUM_CORES-1:0] req_dbl;
  logic [NUM_CORES-1:0]   req_rot;
  logic [IDX_W-1:0]       win_off;
  logic [IDX_W:0]         win_sum;
  logic [IDX_W-1:0]       winner;

  assign any_req = |req;
  assign req_dbl = {req, req};
  assign req_rot = NUM_CORES'(req_dbl >> ptr);

  always_comb begin
    win_off = '0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        win_off = IDX_W'(j);
      end
    end
  end

  // Convert the offset back into an absolute core index. The wrap is
  // explicit so that a non-power-of-two NUM_CORES also wraps correctly.
  always_comb begin
    win_sum = {1'b0, ptr} + {1'b0, win_off};
    if (win_sum >= (IDX_W+1)'(NUM_CORES)) begin
      win_sum = win_sum - (IDX_W+1)'(NUM_CORES);
    end
    winner = win_sum[IDX_W-1:0];
  end

  // Main FSM. IDLE latches the winner and moves to RESP whenever any core is
  // requesting. RESP always lasts exactly one cycle and advances the pointer
  // past the core that was just served.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gidx  <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gidx  <= winner;
            state <= RESP;
          end
        end
        RESP: begin
          if (gidx == IDX_W'(NUM_CORES - 1)) begin
            ptr <= '0;
          end else begin
            ptr <= gidx + IDX_W'(1);
          end
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // done comes only from registered state and gidx, so it cannot glitch
  // towards a core that has not been granted.
  always_comb begin
    done = '0;
    if (state == RESP) begin
      done[gidx] = 1'b1;
    end
  end

  assign stall = req & ~done;
  assign rdata = (state == RESP) ? sram_rdata : 32'h0;

  // SRAM drive. In IDLE the winner is presented combinationally, so a store
  // commits at the IDLE->RESP edge. In RESP the granted address stays on the
  // bus. The reset term forces zeros while reset is held; in particular it
  // blocks any write even though req may still be asserted.
  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    sram_we    = 1'b0;
    if (reset) begin
      if (state == RESP) begin
        sram_addr  = addr_arr[gidx];
        sram_wdata = wdata_arr[gidx];
      end else if (any_req) begin
        sram_addr  = addr_arr[winner];
        sram_wdata = wdata_arr[winner];
        sram_we    = we[winner];
      end
    end
  end

`ifdef DMEM_ARBITER_STATS_EN
  // Per-core completion counters. They saturate at all-ones instead of
  // wrapping, so that a long run never looks like a small count.
  logic [15:0] cnt [NUM_CORES];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (done[i] && (cnt[i] != 16'hFFFF)) begin
          cnt[i] <= cnt[i] + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_cnt
    assign grant_cnt[g*16 +: 16] = cnt[g];
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Purpose:
//   Self-checking bench for dmem_arbiter. The bench holds a small SRAM model
//   and a reference model of the arbitration rules. The reference model
//   serves the first pending core at or after the pointer, then moves the
//   pointer just past that core. Directed scenarios run first, followed by
//   randomized traffic.
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int NumCores = 4;
  localparam int AddrW    = 32;

  logic                       clk = 1'b0;
  logic                       reset;
  logic [NumCores-1:0]        req;
  logic [NumCores-1:0]        we;
  logic [NumCores*AddrW-1:0]  addr;
  logic [NumCores*32-1:0]     wdata;
  logic [NumCores-1:0]        stall;
  logic [31:0]                rdata;
  logic [NumCores-1:0]        done;
  logic [AddrW-1:0]           sramAddr;
  logic                       sramWe;
  logic [31:0]                sramWdata;
  logic [31:0]                sramRdata;
`ifdef DMEM_ARBITER_STATS_EN
  logic [NumCores*16-1:0]     grantCnt;
`endif

  int compareCount  = 0;
  int mismatchCount = 0;

  dmem_arbiter #(
    .NUM_CORES(NumCores),
    .ADDR_W   (AddrW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .rdata     (rdata),
    .done      (done),
    .sram_addr (sramAddr),
    .sram_we   (sramWe),
    .sram_wdata(sramWdata),
    .sram_rdata(sramRdata)
`ifdef DMEM_ARBITER_STATS_EN
    ,
    .grant_cnt (grantCnt)
`endif
  );

  always #5 clk = ~clk;

  // Initial memory contents, restored on every reset in both the SRAM model
  // and the reference copy.
  function automatic logic [31:0] memInit(input int i);
    return 32'hC0DE0000 ^ (32'(i) * 32'h00010101);
  endfunction

  // Synchronous-read SRAM with 64 words, addressed by byte address bits [7:2].
  logic [31:0] sramMem [64];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) begin
        sramMem[i] <= memInit(i);
      end
    end else begin
      if (sramWe) begin
        sramMem[sramAddr[7:2]] <= sramWdata;
      end
      sramRdata <= sramMem[sramAddr[7:2]];
    end
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual,
               expected, $time);
    end
  endtask

  // Reference model state.
  logic                modelBusy = 1'b0;
  int                  modelPtr  = 0;
  int                  modelGidx = 0;
  logic                modelWe   = 1'b0;
  logic [31:0]         modelRdata;
  logic [31:0]         refMem [64];
  int                  served [NumCores];
  logic [NumCores-1:0] lastDone = '0;

  // The reference model is evaluated on each falling edge, after the inputs
  // have settled. A pending access completes in the next cycle. When the
  // model is free, the first requester at or after the pointer is served.
  always @(negedge clk) begin
    logic [NumCores-1:0] expDone;
    int                  w;
    logic [31:0]         a;
    logic [31:0]         d;
    lastDone = done;
    if (!reset) begin
      modelBusy = 1'b0;
      modelPtr  = 0;
      for (int i = 0; i < 64; i++) refMem[i] = memInit(i);
      for (int i = 0; i < NumCores; i++) served[i] = 0;
      checkOutput("rst_done", 64'(done), 64'(0));
      checkOutput("rst_sram_we", 64'(sramWe), 64'(0));
      checkOutput("rst_sram_addr", 64'(sramAddr), 64'(0));
      checkOutput("rst_sram_wdata", 64'(sramWdata), 64'(0));
      checkOutput("rst_rdata", 64'(rdata), 64'(0));
      checkOutput("rst_stall", 64'(stall), 64'(req));
    end else begin
      expDone = '0;
      if (modelBusy) expDone[modelGidx] = 1'b1;
      checkOutput("done", 64'(done), 64'(expDone));
      checkOutput("stall", 64'(stall), 64'(req & ~expDone));
      if (modelBusy) begin
        if (!modelWe) checkOutput("rdata", 64'(rdata), 64'(modelRdata));
        served[modelGidx]++;
        modelBusy = 1'b0;
        modelPtr  = (modelGidx + 1) % NumCores;
      end else if (req != '0) begin
        w = -1;
        for (int k = 0; k < NumCores; k++) begin
          if (w < 0 && req[(modelPtr + k) % NumCores]) w = (modelPtr + k) % NumCores;
        end
        a = addr[w*AddrW +: AddrW];
        d = wdata[w*32 +: 32];
        checkOutput("sram_addr", 64'(sramAddr), 64'(a));
        checkOutput("sram_we", 64'(sramWe), 64'(we[w]));
        if (we[w]) begin
          checkOutput("sram_wdata", 64'(sramWdata), 64'(d));
          refMem[a[7:2]] = d;
        end else begin
          modelRdata = refMem[a[7:2]];
        end
        modelBusy = 1'b1;
        modelGidx = w;
        modelWe   = we[w];
      end else begin
        checkOutput("idle_sram_we", 64'(sramWe), 64'(0));
      end
    end
  end

  // Starts a new access on one core and holds it until the core sees done.
  task automatic applyStimulus(input int core, input logic isStore,
                               input logic [31:0] a, input logic [31:0] d);
    req[core]                  = 1'b1;
    we[core]                   = isStore;
    addr[core*AddrW +: AddrW]  = a;
    wdata[core*32 +: 32]       = d;
  endtask

  // Advances one cycle. A core that completed drops its request. An idle
  // core issues a new random access with probability pct percent.
  task automatic stepCores(input int pct);
    logic [5:0] word;
    @(posedge clk);
    #1;
    for (int i = 0; i < NumCores; i++) begin
      if (req[i] && lastDone[i]) req[i] = 1'b0;
      if (!req[i] && ($urandom_range(99) < pct)) begin
        word = 6'($urandom_range(63));
        applyStimulus(i, 1'($urandom_range(1)), {24'h0, word, 2'b00}, $urandom);
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    we    = '0;
    addr  = '0;
    wdata = '0;

    // Requests and store enables held during reset: nothing may be written.
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(1, 1'b1, 32'h44, 32'h11111111);
    applyStimulus(3, 1'b1, 32'h48, 32'h22222222);
    repeat (2) @(posedge clk);
    #1;
    req   = '0;
    reset = 1'b1;

    // Single store followed by a single load on core 1.
    applyStimulus(1, 1'b1, 32'h40, 32'hDEADBEEF);
    repeat (2) stepCores(0);
    applyStimulus(1, 1'b0, 32'h40, 32'h0);
    repeat (2) stepCores(0);

    // Store then load on core 0.
    applyStimulus(0, 1'b1, 32'h10, 32'h12345678);
    repeat (2) stepCores(0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    repeat (2) stepCores(0);

    // Pointer wrap: serve core 2, then cores 0 and 3 contend (3 goes first).
    applyStimulus(2, 1'b0, 32'h20, 32'h0);
    repeat (2) stepCores(0);
    applyStimulus(0, 1'b0, 32'h04, 32'h0);
    applyStimulus(3, 1'b0, 32'h08, 32'h0);
    repeat (4) stepCores(0);

    // Reset during the RESP cycle of a store granted to core 2.
    applyStimulus(2, 1'b1, 32'h30, 32'hCAFEF00D);
    stepCores(0);
    reset = 1'b0;
    #1;
    checkOutput("rst_mid_done", 64'(done), 64'(0));
    checkOutput("rst_mid_we", 64'(sramWe), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    req   = '0;
    reset = 1'b1;

    // All four cores contend with the pointer at 0 after reset.
    for (int i = 0; i < NumCores; i++) begin
      applyStimulus(i, 1'b0, 32'(64 + 4*i), 32'h0);
    end
    repeat (10) stepCores(0);

    // Randomized traffic.
    doReset();
    repeat (600) stepCores(40);
    repeat (12) stepCores(0);

`ifdef DMEM_ARBITER_STATS_EN
    for (int i = 0; i < NumCores; i++) begin
      checkOutput("grant_cnt", 64'(grantCnt[i*16 +: 16]),
                  64'((served[i] > 65535) ? 16'hFFFF : 16'(served[i])));
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount,
             mismatchCount);
    $finish;
  end

endmodule
